// File: rtl/shift_sequencer_if.sv
// Request/response bundle between the ALU issue logic (master) and the
// iterative shift sequencer (slave).
interface shift_sequencer_if #(
   parameter int WIDTH   = 32,
   parameter int SHAMT_W = 5
);
   logic               start;
   logic [1:0]         op;
   logic [WIDTH-1:0]   data_in;
   logic [SHAMT_W-1:0] shamt;
   logic               busy;
   logic               done;
   logic [WIDTH-1:0]   result;
   logic [SHAMT_W-1:0] stage_sel;

   modport master (
      output start, op, data_in, shamt,
      input  busy, done, result, stage_sel
   );

   modport slave (
      input  start, op, data_in, shamt,
      output busy, done, result, stage_sel
   );
endinterface

// File: rtl/shift_sequencer.sv
// Iterative log-shifter: one stage (1,2,4,8,16) per clock behind a start/busy/done handshake.
// Optional SHIFT_SEQ_EARLY_EXIT_EN finishes as soon as no higher shamt bits remain.
module shift_sequencer #(
   parameter int WIDTH   = 32,
   parameter int SHAMT_W = 5
) (
   input  logic              clk,
   input  logic              rst,
   shift_sequencer_if.slave  bus
);
   localparam int STAGE_W = $clog2(SHAMT_W);
   localparam logic [STAGE_W-1:0] LAST_STAGE = STAGE_W'(SHAMT_W - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [STAGE_W-1:0] stage_q, stage_d;
   logic [1:0]         op_q, op_d;
   logic [SHAMT_W-1:0] shamt_q, shamt_d;
   logic [WIDTH-1:0]   result_q, result_d;

   logic                             busy, done;
   logic [SHAMT_W-1:0]               stage_sel;
   logic [SHAMT_W-1:0][WIDTH-1:0]    masked_word;
   logic [WIDTH-1:0]                 stage_word;
   logic                             step_taken;
   logic                             last_stage;

   // Each stage has its own fixed-distance word mux; only the selected,
   // enabled stage contributes to the OR-combined stage_word.
   generate
      for (genvar gi = 0; gi < SHAMT_W; gi++) begin : g_stage
         localparam int K = 1 << gi;
         logic [WIDTH-1:0] step_word;

         assign step_word =
            (op_q == 2'b00) ? {result_q[WIDTH-1-K:0], {K{1'b0}}} :
            (op_q == 2'b01) ? {{K{1'b0}}, result_q[WIDTH-1:K]} :
            (op_q == 2'b10) ? {{K{result_q[WIDTH-1]}}, result_q[WIDTH-1:K]} :
                              {result_q[K-1:0], result_q[WIDTH-1:K]};

         assign masked_word[gi] = (stage_sel[gi] && shamt_q[gi]) ? step_word : '0;
      end
   endgenerate

   always_comb begin
      stage_word = '0;
      for (int i = 0; i < SHAMT_W; i++) begin
         stage_word = stage_word | masked_word[i];
      end
   end

   assign step_taken = |(stage_sel & shamt_q);

`ifdef SHIFT_SEQ_EARLY_EXIT_EN
   assign last_stage = (stage_q == LAST_STAGE) ||
                       ((shamt_q >> (stage_q + 1'b1)) == '0);
`else
   assign last_stage = (stage_q == LAST_STAGE);
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         stage_q  <= '0;
         op_q     <= '0;
         shamt_q  <= '0;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         stage_q  <= stage_d;
         op_q     <= op_d;
         shamt_q  <= shamt_d;
         result_q <= result_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      stage_d  = stage_q;
      op_d     = op_q;
      shamt_d  = shamt_q;
      result_d = result_q;
      case (state_q)
         IDLE: begin
            if (bus.start) begin
               op_d     = bus.op;
               shamt_d  = bus.shamt;
               result_d = bus.data_in;
               stage_d  = '0;
               state_d  = SHIFT;
`ifdef SHIFT_SEQ_EARLY_EXIT_EN
               if (bus.shamt == '0) begin
                  state_d = DONE;
               end
`endif
            end
         end
         SHIFT: begin
            if (step_taken) begin
               result_d = stage_word;
            end
            if (last_stage) begin
               state_d = DONE;
            end else begin
               stage_d = stage_q + 1'b1;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      busy      = (state_q != IDLE);
      done      = (state_q == DONE);
      stage_sel = (state_q == SHIFT) ? (SHAMT_W'(1) << stage_q) : '0;
   end

   assign bus.busy      = busy;
   assign bus.done      = done;
   assign bus.stage_sel = stage_sel;
   assign bus.result    = result_q;
endmodule

// File: tb/tb_shift_sequencer.sv
// Randomized and directed bench for shift_sequencer against an arithmetic shift model.
module tb_shift_sequencer;
   logic clk;
   logic rst;
   int   total = 0;
   int   bad   = 0;

   shift_sequencer_if #(.WIDTH(32), .SHAMT_W(5)) bus ();

   shift_sequencer #(.WIDTH(32), .SHAMT_W(5)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] ref_shift(input logic [1:0] op, input logic [31:0] d,
                                             input logic [4:0] s);
      logic [63:0] w;
      case (op)
         2'd0:    ref_shift = d << s;
         2'd1:    ref_shift = d >> s;
         2'd2:    ref_shift = 32'($signed(d) >>> s);
         default: begin
            w = {d, d} >> s;
            ref_shift = w[31:0];
         end
      endcase
   endfunction

   // Clock edges from the accepting edge (inclusive) until done is visible.
   function automatic int ref_lat(input logic [4:0] s);
`ifdef SHIFT_SEQ_EARLY_EXIT_EN
      ref_lat = 1;
      for (int i = 0; i < 5; i++) begin
         if (s[i]) ref_lat = i + 2;
      end
`else
      ref_lat = 6;
`endif
   endfunction

   task automatic run_req(input logic [1:0] op, input logic [31:0] d, input logic [4:0] s,
                          input bit collide);
      logic [31:0] exp;
      int          n;
      exp = ref_shift(op, d, s);
      n   = ref_lat(s);
      bus.start   = 1'b1;
      bus.op      = op;
      bus.data_in = d;
      bus.shamt   = s;
      @(posedge clk); #1;
      bus.start = 1'b0;
      for (int j = 0; j < n; j++) begin
         check_val("busy", 32'(bus.busy), 32'd1);
         check_val("done", 32'(bus.done), 32'(j == n - 1));
         check_val("stage_sel", 32'(bus.stage_sel), (j < n - 1) ? (32'd1 << j) : 32'd0);
         if (j == n - 1) check_val("result", bus.result, exp);
         bus.op      = 2'($urandom);
         bus.data_in = collide ? 32'hAAAAAAAA : $urandom;
         bus.shamt   = 5'($urandom);
         bus.start   = collide && (j == 1 || j == n - 1);
         @(posedge clk); #1;
      end
      check_val("idle_busy", 32'(bus.busy), 32'd0);
      check_val("idle_done", 32'(bus.done), 32'd0);
      check_val("hold_result", bus.result, exp);
      bus.start = 1'b0;
      $display("req op=%0d data=0x%08h shamt=%0d -> result=0x%08h (expected 0x%08h) lat=%0d",
               op, d, s, bus.result, exp, n);
   endtask

   initial begin
      rst         = 1'b1;
      bus.start   = 1'b0;
      bus.op      = 2'd0;
      bus.data_in = 32'h0;
      bus.shamt   = 5'd0;
      repeat (2) @(posedge clk);
      #1;
      check_val("rst_busy", 32'(bus.busy), 32'd0);
      check_val("rst_done", 32'(bus.done), 32'd0);
      check_val("rst_result", bus.result, 32'd0);
      check_val("rst_stage_sel", 32'(bus.stage_sel), 32'd0);
      #2 rst = 1'b0;
      @(posedge clk); #1;

      run_req(2'd0, 32'h00000001, 5'd31, 1'b0);
      run_req(2'd2, 32'h80000000, 5'd4,  1'b0);
      run_req(2'd1, 32'hFFFFFFFF, 5'd1,  1'b0);
      run_req(2'd3, 32'h12345678, 5'd8,  1'b0);
      run_req(2'd3, 32'h12345678, 5'd0,  1'b0);
      run_req(2'd2, 32'h80000001, 5'd31, 1'b0);
      run_req(2'd0, 32'hDEADBEEF, 5'd1,  1'b0);
      run_req(2'd1, 32'hDEADBEEF, 5'd3,  1'b0);
      run_req(2'd2, 32'hDEADBEEF, 5'd16, 1'b0);
      run_req(2'd0, 32'h0000000F, 5'd4,  1'b1);

      // Asynchronous reset in the middle of a shift must clear everything at once.
      bus.start   = 1'b1;
      bus.op      = 2'd1;
      bus.data_in = 32'h80000000;
      bus.shamt   = 5'd31;
      @(posedge clk); #1;
      bus.start = 1'b0;
      repeat (3) @(posedge clk);
      #3 rst = 1'b1;
      #1;
      check_val("abort_busy", 32'(bus.busy), 32'd0);
      check_val("abort_done", 32'(bus.done), 32'd0);
      check_val("abort_result", bus.result, 32'd0);
      check_val("abort_stage_sel", 32'(bus.stage_sel), 32'd0);
      #1 rst = 1'b0;
      repeat (3) begin
         @(posedge clk); #1;
         check_val("abort_no_done", 32'(bus.done), 32'd0);
      end
      run_req(2'd1, 32'h00000100, 5'd8, 1'b0);

      for (int t = 0; t < 40; t++) begin
         run_req(2'($urandom), $urandom, 5'($urandom), 1'($urandom_range(0, 3) == 0));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
